// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg: shared state encoding, counter limit and default widths for the fetch sequencer
package fetch_seq_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int REG_W_DEF  = 3;
    localparam logic [7:0] REDIRECT_CNT_MAX = 8'd255;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        FLUSH   = 2'd2,
        HALT    = 2'd3
    } state_e;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == REDIRECT_CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fetch_sequencer_hazard_unit.sv
// hazard_unit: combinational load-use comparator between the EX destination and the ID sources
//   ex_is_load_i, ex_rd_i            : EX instruction is a load and its destination
//   id_rs1_i/_rs2_i, id_rs*_used_i   : ID source specifiers and whether each is read
//   hazard_o                         : ID reads a register the EX load has not yet produced
module hazard_unit
    import fetch_seq_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic             ex_is_load_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    output logic             hazard_o
);

    assign hazard_o = ex_is_load_i & ((id_rs1_used_i & (id_rs1_i == ex_rd_i)) |
                                      (id_rs2_used_i & (id_rs2_i == ex_rd_i)));

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: load-use stall, branch-redirect flush and optional HALT control for the fetch stage
//   Optional feature macro: FETCH_SEQ_HALT_EN (honours id_is_halt, adds HALT state and halted)
//   clk, reset (async, active-low)
//   ex_is_load, ex_rd, id_rs1/2, id_rs1/2_used : load-use hazard inputs
//   ex_br_taken, ex_br_target                  : taken-branch redirect from EX
//   id_is_halt                                 : HALT in ID (ignored without the macro)
//   stall, stall_pm, pc_mux_sel, jmp_loc       : PC / program-memory controls
//   flush, bubble                              : IF/ID squash and ID/EX NOP insertion
//   halted, redirect_cnt                       : core parked flag, saturating redirect count
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int REG_W        = REG_W_DEF,
    parameter int STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_is_load,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              ex_br_taken,
    input  logic [ADDR_W-1:0] ex_br_target,
    input  logic              id_is_halt,
    output logic              stall,
    output logic              stall_pm,
    output logic              pc_mux_sel,
    output logic [ADDR_W-1:0] jmp_loc,
    output logic              flush,
    output logic              bubble,
    output logic              halted,
    output logic [7:0]        redirect_cnt
);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       stall_pm_q;
    logic [7:0] redirect_cnt_q;
    logic       hazard, br, haz;

    hazard_unit #(.REG_W(REG_W)) u_hazard (
        .ex_is_load_i  (ex_is_load),
        .ex_rd_i       (ex_rd),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_rs1_used_i (id_rs1_used),
        .id_rs2_used_i (id_rs2_used),
        .hazard_o      (hazard)
    );

    // Qualified by reset so every combinational output drops the instant reset asserts.
    assign br  = ex_br_taken & reset;
    assign haz = hazard & reset;

    assign pc_mux_sel   = br;
    assign jmp_loc      = br ? ex_br_target : '0;
    assign stall_pm     = stall_pm_q;
    assign redirect_cnt = redirect_cnt_q;

`ifdef FETCH_SEQ_HALT_EN
    assign halted = (state_q == HALT);
`else
    logic unused_halt;
    assign unused_halt = id_is_halt;
    assign halted      = 1'b0;
`endif

    // cnt_q holds the remaining extra cycles of whichever of LDSTALL/FLUSH is active.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        bubble  = 1'b0;
        flush   = 1'b0;
        if (br) begin
            flush   = 1'b1;
            cnt_d   = 3'(FLUSH_CYCLES - 1);
            state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else begin
            case (state_q)
                RUN: begin
                    stall   = haz;
                    bubble  = haz;
                    cnt_d   = 3'(STALL_CYCLES - 1);
                    state_d = (haz && STALL_CYCLES > 1) ? LDSTALL : RUN;
`ifdef FETCH_SEQ_HALT_EN
                    if (!haz && id_is_halt) state_d = HALT;
`endif
                end
                LDSTALL: begin
                    stall   = 1'b1;
                    bubble  = 1'b1;
                    cnt_d   = cnt_q - 3'd1;
                    state_d = (cnt_q == 3'd1) ? RUN : LDSTALL;
                end
                FLUSH: begin
                    flush   = 1'b1;
                    cnt_d   = cnt_q - 3'd1;
                    state_d = (cnt_q == 3'd1) ? RUN : FLUSH;
                end
`ifdef FETCH_SEQ_HALT_EN
                HALT: begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                end
`endif
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= RUN;
            cnt_q          <= '0;
            stall_pm_q     <= 1'b0;
            redirect_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_pm_q     <= stall;
            redirect_cnt_q <= br ? sat_inc(redirect_cnt_q) : redirect_cnt_q;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scoreboard bench for fetch_sequencer (STALL_CYCLES=1 and 3 instances)
module tb_fetch_sequencer;

`ifdef FETCH_SEQ_HALT_EN
    localparam bit HE = 1'b1;
`else
    localparam bit HE = 1'b0;
`endif

    typedef struct packed {
        logic       s1;
        logic       spm;
        logic       b;
        logic       s3;
        logic       pc;
        logic [7:0] jl;
        logic       fl;
        logic       h;
        logic [7:0] c;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       ex_is_load, id_rs1_used, id_rs2_used, ex_br_taken, id_is_halt;
    logic [2:0] ex_rd, id_rs1, id_rs2;
    logic [7:0] ex_br_target;

    logic       stall1, stall_pm1, pc1, flush1, bubble1, halted1;
    logic [7:0] jmp1, cnt1;
    logic       stall3, stall_pm3, pc3, flush3, bubble3, halted3;
    logic [7:0] jmp3, cnt3;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.STALL_CYCLES(1), .FLUSH_CYCLES(2)) d1 (
        .clk(clk), .reset(reset), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target), .id_is_halt(id_is_halt),
        .stall(stall1), .stall_pm(stall_pm1), .pc_mux_sel(pc1), .jmp_loc(jmp1),
        .flush(flush1), .bubble(bubble1), .halted(halted1), .redirect_cnt(cnt1)
    );

    fetch_sequencer #(.STALL_CYCLES(3), .FLUSH_CYCLES(2)) d3 (
        .clk(clk), .reset(reset), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target), .id_is_halt(id_is_halt),
        .stall(stall3), .stall_pm(stall_pm3), .pc_mux_sel(pc3), .jmp_loc(jmp3),
        .flush(flush3), .bubble(bubble3), .halted(halted3), .redirect_cnt(cnt3)
    );

    // Drive one cycle of inputs just after the rising edge and queue what that cycle must show.
    task automatic vec(input string nm, input logic rs, ld, input logic [2:0] rd, r1, input logic u1,
                       input logic [2:0] r2, input logic u2, br, input logic [7:0] tgt, input logic hl,
                       input logic s1, spm, b, s3, pc, input logic [7:0] jl, input logic fl, h,
                       input logic [7:0] c);
        @(posedge clk);
        #1;
        reset = rs; ex_is_load = ld; ex_rd = rd; id_rs1 = r1; id_rs1_used = u1;
        id_rs2 = r2; id_rs2_used = u2; ex_br_taken = br; ex_br_target = tgt; id_is_halt = hl;
        exp_q.push_back('{s1, spm, b, s3, pc, jl, fl, h, c});
        name_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e, a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = '{stall1, stall_pm1, bubble1, stall3, pc1, jmp1, flush1, halted1, cnt1};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL %s: got s1=%b spm=%b b=%b s3=%b pc=%b jl=%h fl=%b h=%b cnt=%0d, want s1=%b spm=%b b=%b s3=%b pc=%b jl=%h fl=%b h=%b cnt=%0d",
                         nm, a.s1, a.spm, a.b, a.s3, a.pc, a.jl, a.fl, a.h, a.c,
                         e.s1, e.spm, e.b, e.s3, e.pc, e.jl, e.fl, e.h, e.c);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; ex_is_load = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        id_rs1_used = 0; id_rs2_used = 0; ex_br_taken = 0; ex_br_target = 0; id_is_halt = 0;
        #1 reset = 1'b0;
        //       name        rs ld rd r1 u1 r2 u2 br tgt    hl   s1 spm b s3 pc jl    fl h cnt
        vec("reset",         0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        vec("idle",          1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        vec("hazard",        1, 1, 3, 3, 1, 0, 0, 0, 8'h00, 0,   1, 0, 1, 1, 0, 8'h00, 0, 0, 0);
        vec("hazard_t1",     1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 1, 0, 1, 0, 8'h00, 0, 0, 0);
        vec("hazard_t2",     1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 1, 0, 8'h00, 0, 0, 0);
        vec("hazard_t3",     1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        vec("unused_src",    1, 1, 3, 3, 0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        vec("rs2_hazard",    1, 1, 5, 3, 1, 5, 1, 0, 8'h00, 0,   1, 0, 1, 1, 0, 8'h00, 0, 0, 0);
        vec("not_load",      1, 0, 3, 3, 1, 0, 0, 0, 8'h00, 0,   0, 1, 0, 1, 0, 8'h00, 0, 0, 0);
        vec("not_load_t2",   1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 1, 0, 8'h00, 0, 0, 0);
        vec("branch",        1, 0, 0, 0, 0, 0, 0, 1, 8'h40, 0,   0, 0, 0, 0, 1, 8'h40, 1, 0, 0);
        vec("branch_t1",     1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 8'h00, 1, 0, 1);
        vec("branch_t2",     1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 8'h00, 0, 0, 1);
        vec("br_and_haz",    1, 1, 3, 3, 1, 0, 0, 1, 8'h22, 0,   0, 0, 0, 0, 1, 8'h22, 1, 0, 1);
        vec("br_and_haz_t1", 1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 8'h00, 1, 0, 2);
        vec("br_and_haz_t2", 1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 8'h00, 0, 0, 2);
        vec("haz_pre_br",    1, 1, 3, 3, 1, 0, 0, 0, 8'h00, 0,   1, 0, 1, 1, 0, 8'h00, 0, 0, 2);
        vec("br_in_ldstall", 1, 0, 0, 0, 0, 0, 0, 1, 8'h80, 0,   0, 1, 0, 0, 1, 8'h80, 1, 0, 2);
        vec("ldstall_gone",  1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 8'h00, 1, 0, 3);
        vec("ldstall_gone2", 1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 8'h00, 0, 0, 3);
        vec("br_a",          1, 0, 0, 0, 0, 0, 0, 1, 8'h10, 0,   0, 0, 0, 0, 1, 8'h10, 1, 0, 3);
        vec("br_in_flush",   1, 0, 0, 0, 0, 0, 0, 1, 8'h11, 0,   0, 0, 0, 0, 1, 8'h11, 1, 0, 4);
        vec("reflush_t1",    1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 8'h00, 1, 0, 5);
        vec("reflush_t2",    1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 8'h00, 0, 0, 5);
        for (int k = 0; k < 12; k++)
            vec("halt_hold",  1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1,
                HE && k >= 1, HE && k >= 2, HE && k >= 1, HE && k >= 1, 0, 8'h00, 0, HE && k >= 1, 5);
        vec("halt_release",  1, 0, 0, 0, 0, 0, 0, 1, 8'h55, 0,   0, HE, 0, 0, 1, 8'h55, 1, HE, 5);
        vec("halt_rel_t1",   1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 8'h00, 1, 0, 6);
        vec("halt_rel_t2",   1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 8'h00, 0, 0, 6);
        vec("haz_pre_rst",   1, 1, 3, 3, 1, 0, 0, 0, 8'h00, 0,   1, 0, 1, 1, 0, 8'h00, 0, 0, 6);
        vec("in_ldstall",    1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 1, 0, 1, 0, 8'h00, 0, 0, 6);
        vec("rst_ldstall",   0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        vec("rst_ld_rel",    1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        vec("br_pre_rst",    1, 0, 0, 0, 0, 0, 0, 1, 8'h33, 0,   0, 0, 0, 0, 1, 8'h33, 1, 0, 0);
        vec("rst_flush",     0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        vec("rst_fl_rel",    1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 300; i++)
            vec("saturate",   1, 0, 0, 0, 0, 0, 0, 1, 8'(i), 0,
                0, 0, 0, 0, 1, 8'(i), 1, 0, (i >= 255) ? 8'd255 : 8'(i));
        vec("sat_t1",        1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 8'h00, 1, 0, 255);
        vec("sat_hold",      1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 8'h00, 0, 0, 255);
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
